// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

    typedef logic [1:0] sa_state_t;

    localparam sa_state_t ST_IDLE = 2'd0;
    localparam sa_state_t ST_RUN  = 2'd1;
    localparam sa_state_t ST_DONE = 2'd2;

    localparam int SA_WIDTH_DEFAULT = 8;

endpackage : serial_adder_pkg

// File: rtl/fulladder_using_decoder.sv
// One-bit full adder built from a 3-to-8 one-hot decoder of {a,b,c}.
// sum is the OR of the odd-parity minterms, carry the OR of the
// minterms with two or more ones. The decoder lines are exported.
module fulladder_using_decoder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7
);

    logic [7:0] w_dec;

    // One-hot decode of the three input bits
    always_comb begin
        w_dec = 8'b0000_0001 << {a, b, c};
    end

    assign {y7, y6, y5, y4, y3, y2, y1, y0} = w_dec;

    assign sum   = w_dec[1] | w_dec[2] | w_dec[4] | w_dec[7];
    assign carry = w_dec[3] | w_dec[5] | w_dec[6] | w_dec[7];

endmodule : fulladder_using_decoder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Sequences one shared full-adder cell over
// WIDTH cycles, LSB first, and owns operand/result shift registers, the
// carry flop, the bit counter and the start/busy/done handshake.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port
// (two's-complement a_in - b_in; carry_out=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_cy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_load_b;
    logic             w_load_cy;

    // Subtraction is a + ~b + 1: invert B on load and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_load_b  = sub ? ~b_in : b_in;
    assign w_load_cy = sub;
`else
    assign w_load_b  = b_in;
    assign w_load_cy = 1'b0;
`endif

    fulladder_using_decoder u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_cy),
        .sum   (w_fa_sum),
        .carry (w_fa_carry),
        .y0    (),
        .y1    (),
        .y2    (),
        .y3    (),
        .y4    (),
        .y5    (),
        .y6    (),
        .y7    ()
    );

    // FSM, shift registers, carry flop, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_s_sr    <= '0;
            r_cy      <= 1'b0;
            r_cnt     <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a_in;
                        r_b_sr  <= w_load_b;
                        r_cy    <= w_load_cy;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s_sr <= {w_fa_sum, r_s_sr[WIDTH-1:1]};
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_cy   <= w_fa_carry;
                    if (r_cnt == CNT_LAST) begin
                        // Counter holds on the last bit so it never wraps.
                        sum_out   <= {w_fa_sum, r_s_sr[WIDTH-1:1]};
                        carry_out <= w_fa_carry;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Directed and
// randomized operations are compared with a plain-arithmetic model.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result of a_in op b_in as a WIDTH-bit value plus carry flag.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        int unsigned r;
        logic [W:0] res;
        if (s) begin
            r = (int'(a) - int'(b) + 256) % 256;
            res = {(a >= b), r[W-1:0]};
        end else begin
            r = int'(a) + int'(b);
            res = {(r > 255), r[W-1:0]};
        end
        return res;
    endfunction

    // Issue one start pulse from IDLE and follow the operation to done.
    // lat counts cycles from raising start to the cycle with done high (-1 on timeout).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] res, output logic cy);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sub = s;
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_cnt = 0; res = 'x; cy = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = i; res = sum_out; cy = carry_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        start = 1'b0; a_in = '0; b_in = '0; sub = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum_out); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry_out); end
        // start together with rst must be dropped
        start = 1'b1; a_in = 8'h12; b_in = 8'h34;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_drop: busy got %b want 0", busy); end
    endtask

    task automatic test_zero;
        int lat, bc; logic [W-1:0] r; logic c;
        do_op(8'h00, 8'h00, 1'b0, lat, bc, r, c);
        checks++; if (lat != 9) begin errors++; $display("FAIL zero_latency: got %0d want 9", lat); end
        checks++; if (bc != 8) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 8", bc); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL zero_sum: got %h want 00", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL zero_carry: got %b want 0", c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
    endtask

    task automatic test_overflow;
        int lat, bc; logic [W-1:0] r; logic c;
        do_op(8'hFF, 8'h01, 1'b0, lat, bc, r, c);
        checks++; if (lat != 9) begin errors++; $display("FAIL ovf_latency: got %0d want 9", lat); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ovf_sum: got %h want 00", r); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_carry: got %b want 1", c); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start;
        int ndone = 0; int first = -1;
        logic [W-1:0] r = 'x; logic c = 1'bx;
        @(negedge clk);
        start = 1'b1; a_in = 8'hA5; b_in = 8'h5A; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 8'h11; b_in = 8'h22;
        @(negedge clk);
        start = 1'b0;
        for (int i = 4; i <= 25; i++) begin
            if (done) begin
                ndone++;
                if (first < 0) begin first = i; r = sum_out; c = carry_out; end
            end
            @(negedge clk);
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
        checks++; if (first != 9) begin errors++; $display("FAIL ign_latency: got %0d want 9", first); end
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL ign_sum: got %h want ff", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL ign_carry: got %b want 0", c); end
        checks++; if (sum_out !== 8'hFF) begin errors++; $display("FAIL ign_sum_hold: got %h want ff", sum_out); end
    endtask

    task automatic test_back_to_back;
        int npulse = 0; int last = -1;
        @(negedge clk);
        start = 1'b1; a_in = 8'h0F; b_in = 8'h01; sub = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (last >= 0) begin
                checks++;
                if (sum_out !== 8'h10) begin errors++; $display("FAIL b2b_stable: cycle %0d got %h want 10", i, sum_out); end
            end
            if (done) begin
                npulse++;
                if (last >= 0) begin
                    checks++;
                    if (i - last != 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", i - last); end
                end else begin
                    checks++;
                    if (sum_out !== 8'h10) begin errors++; $display("FAIL b2b_sum: got %h want 10", sum_out); end
                end
                last = i;
            end
        end
        start = 1'b0;
        checks++; if (npulse != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", npulse); end
        for (int i = 0; i < 15 && (busy || done); i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; a_in = 8'h80; b_in = 8'h80; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", sum_out); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL abort_carry: got %b want 0", carry_out); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    endtask

    task automatic test_random;
        int lat, bc; logic [W-1:0] r; logic c; logic [W:0] exp;
        logic [W-1:0] a, b; logic s;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            exp = model(a, b, s);
            do_op(a, b, s, lat, bc, r, c);
            checks++;
            if (lat != 9 || r !== exp[W-1:0] || c !== exp[W]) begin
                errors++;
                $display("FAIL rand_op: %h %s %h got lat=%0d sum=%h cy=%b want lat=9 sum=%h cy=%b",
                         a, s ? "-" : "+", b, lat, r, c, exp[W-1:0], exp[W]);
            end
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, bc; logic [W-1:0] r; logic c;
        do_op(8'h10, 8'h01, 1'b1, lat, bc, r, c);
        checks++; if (r !== 8'h0F || c !== 1'b1) begin errors++; $display("FAIL sub_no_borrow: got %h/%b want 0f/1", r, c); end
        @(negedge clk);
        do_op(8'h01, 8'h02, 1'b1, lat, bc, r, c);
        checks++; if (r !== 8'hFF || c !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %h/%b want ff/0", r, c); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_zero;
        test_overflow;
        test_ignored_start;
        test_back_to_back;
        test_reset_abort;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
